// File: rtl/trivium_pkg.sv
// ---------------------------------------------------------------------------
// trivium_pkg
// Shared constants and types for the Trivium keystream core.
//   - geometry of the 288-bit state and its three shift registers
//   - tap positions, written with the 1-based numbering s(1..288) of the
//     cipher description. Subtract one to get a vector bit index.
//   - warm-up length and rounds applied per clock
//   - FSM state enum and the key/IV load helper
// ---------------------------------------------------------------------------
package trivium_pkg;

  localparam int STATE_LEN        = 288;
  localparam int KEY_LEN          = 80;
  localparam int IV_LEN           = 80;
  localparam int WARMUP_ROUNDS    = 1152;
  localparam int ROUNDS_PER_CYCLE = 8;
  localparam int WARMUP_CYCLES    = WARMUP_ROUNDS / ROUNDS_PER_CYCLE;
  localparam int CNT_W            = 8;

  // Last 1-based position of each shift register: A = s1..s93,
  // B = s94..s177, C = s178..s288.
  localparam int A_END = 93;
  localparam int B_END = 177;
  localparam int C_END = 288;

  // Tap positions (1-based).
  localparam int T1_OUT_A = 66;
  localparam int T1_OUT_B = 93;
  localparam int T1_AND_A = 91;
  localparam int T1_AND_B = 92;
  localparam int T1_FB    = 171;

  localparam int T2_OUT_A = 162;
  localparam int T2_OUT_B = 177;
  localparam int T2_AND_A = 175;
  localparam int T2_AND_B = 176;
  localparam int T2_FB    = 264;

  localparam int T3_OUT_A = 243;
  localparam int T3_OUT_B = 288;
  localparam int T3_AND_A = 286;
  localparam int T3_AND_B = 287;
  localparam int T3_FB    = 69;

  typedef logic [STATE_LEN-1:0] trv_state_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_READY,
    ST_REFILL
  } state_e;

  // Builds the load value. Bit (i-1) of the vector holds s(i).
  // The key fills s1..s80 and the IV fills s94..s173. s286..s288 are set
  // to one. Every other bit is zero.
  function automatic trv_state_t load_state(input logic [KEY_LEN-1:0] key,
                                            input logic [IV_LEN-1:0]  iv);
    trv_state_t s;
    s                           = '0;
    s[KEY_LEN-1:0]              = key;
    s[A_END+IV_LEN-1:A_END]     = iv;
    s[C_END-1:C_END-3]          = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_if.sv
// ---------------------------------------------------------------------------
// trivium_if
// Keystream handshake between the core (producer) and its consumer.
//   keystream_byte  : current keystream byte (producer -> consumer)
//   keystream_valid : byte is fresh and not yet consumed (producer -> consumer)
//   keystream_read  : consumer acknowledges the current byte (consumer -> producer)
// Modports:
//   master : producer side (the core)
//   slave  : consumer side
// ---------------------------------------------------------------------------
interface trivium_if;

  logic       keystream_read;
  logic [7:0] keystream_byte;
  logic       keystream_valid;

  modport master (
    input  keystream_read,
    output keystream_byte,
    output keystream_valid
  );

  modport slave (
    output keystream_read,
    input  keystream_byte,
    input  keystream_valid
  );

endinterface

// File: rtl/trivium_round.sv
// ---------------------------------------------------------------------------
// trivium_round
// One purely combinational Trivium round.
//   s_in  : 288-bit state before the round (bit i-1 = s(i))
//   s_out : 288-bit state after the round
//   z     : keystream bit produced by this round
// ---------------------------------------------------------------------------
module trivium_round
  import trivium_pkg::*;
(
  input  trv_state_t s_in,
  output trv_state_t s_out,
  output logic       z
);

  logic t1, t2, t3;
  logic t1_fb, t2_fb, t3_fb;

  always_comb begin
    t1 = s_in[T1_OUT_A-1] ^ s_in[T1_OUT_B-1];
    t2 = s_in[T2_OUT_A-1] ^ s_in[T2_OUT_B-1];
    t3 = s_in[T3_OUT_A-1] ^ s_in[T3_OUT_B-1];

    z  = t1 ^ t2 ^ t3;

    t1_fb = t1 ^ (s_in[T1_AND_A-1] & s_in[T1_AND_B-1]) ^ s_in[T1_FB-1];
    t2_fb = t2 ^ (s_in[T2_AND_A-1] & s_in[T2_AND_B-1]) ^ s_in[T2_FB-1];
    t3_fb = t3 ^ (s_in[T3_AND_A-1] & s_in[T3_AND_B-1]) ^ s_in[T3_FB-1];

    // Each register shifts one place toward higher indices. Its last bit
    // falls off, and the feedback from the other register enters at its
    // first bit: t3 into A, t1 into B, t2 into C.
    s_out = {s_in[C_END-2:B_END], t2_fb,
             s_in[B_END-2:A_END], t1_fb,
             s_in[A_END-2:0],     t3_fb};
  end

endmodule

// File: rtl/trivium_core.sv
// ---------------------------------------------------------------------------
// trivium_core
// Trivium keystream generator that produces one byte per handshake.
// After reset it runs a 144-cycle warm-up, which is 1152 discarded rounds.
// Every state update then applies 8 chained rounds and packs the output
// bits LSB-first into a byte.
// Parameters:
//   KEY : 80-bit key. KEY[i-1] goes to s(i).
//   IV  : 80-bit initialisation vector. IV[i-1] goes to s(93+i).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset. It reloads key/IV and restarts
//         the warm-up.
//   ks  : trivium_if.master. Carries keystream_byte, keystream_valid and
//         keystream_read.
// ---------------------------------------------------------------------------
module trivium_core
  import trivium_pkg::*;
#(
  parameter logic [KEY_LEN-1:0] KEY = '0,
  parameter logic [IV_LEN-1:0]  IV  = '0
) (
  input  logic     clk,
  input  logic     rst,
  trivium_if.master ks
);

  trv_state_t                  chain [ROUNDS_PER_CYCLE+1];
  logic [ROUNDS_PER_CYCLE-1:0] z_bits;

  state_e          state_q, state_d;
  trv_state_t      trv_q,   trv_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [7:0]      byte_q,  byte_d;
  logic            valid_q, valid_d;
  // Set once a read has been honoured. It stays set while the consumer
  // keeps keystream_read high, so a long read consumes only one byte.
  logic            hold_q,  hold_d;

  assign chain[0] = trv_q;

  // The output of round r becomes byte bit r, so the first bit is the LSB.
  for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
    trivium_round u_round (
      .s_in  (chain[r]),
      .s_out (chain[r+1]),
      .z     (z_bits[r])
    );
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    trv_d   = trv_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    hold_d  = ks.keystream_read & hold_q;

    unique case (state_q)
      ST_INIT: begin
        trv_d = chain[ROUNDS_PER_CYCLE];
        // The 144 warm-up cycles discard their output. The cycle after
        // them is the first one whose byte is kept.
        if (cnt_q == CNT_W'(WARMUP_CYCLES)) begin
          byte_d  = z_bits;
          valid_d = 1'b1;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_READY: begin
        // With no new read, state and byte hold, so no byte is skipped.
        if (ks.keystream_read && !hold_q) begin
          valid_d = 1'b0;
          hold_d  = 1'b1;
          state_d = ST_REFILL;
        end
      end

      ST_REFILL: begin
        trv_d   = chain[ROUNDS_PER_CYCLE];
        byte_d  = z_bits;
        valid_d = 1'b1;
        state_d = ST_READY;
      end

      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: the 288-bit state is a set of flip-flops, not a memory, so it is
  // reset here like any other register. Reset reloads the key and IV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      trv_q   <= load_state(KEY, IV);
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give all registers a simultaneous
      // update, whatever order they are written in.
      state_q <= state_d;
      trv_q   <= trv_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign ks.keystream_byte  = byte_q;
  assign ks.keystream_valid = valid_q;

endmodule

// File: tb/tb_trivium_core.sv
// ---------------------------------------------------------------------------
// tb_trivium_core
// Self-checking bench for trivium_core.
// - The main instance uses KEY=0 and IV=0. It covers the warm-up timing, the
//   zero-vector bytes, the read handshake, idle hold and mid-stream /
//   mid-warm-up reset.
// - Ten further instances use fixed arbitrary key/IV sets. They run in
//   lockstep and their bytes are compared against a bit-level software model.
// ---------------------------------------------------------------------------
module tb_trivium_core;
  import trivium_pkg::*;

  localparam int N_SETS  = 10;
  localparam int N_BYTES = 64;

  localparam logic [N_SETS-1:0][79:0] RK_KEY = {
    80'h0123456789ABCDEF0123, 80'hFFFFFFFFFFFFFFFFFFFF,
    80'h80000000000000000000, 80'h00000000000000000001,
    80'hDEADBEEFCAFEBABE1234, 80'h5A5A5A5AA5A5A5A50F0F,
    80'h13579BDF2468ACE01122, 80'hC0FFEE00112233445566,
    80'h0F1E2D3C4B5A69788796, 80'h7E57AB1EFEED5EED0BAD
  };
  localparam logic [N_SETS-1:0][79:0] RK_IV = {
    80'h00000000000000000000, 80'h00000000000000000000,
    80'hFEDCBA98765432100001, 80'h80000000000000000000,
    80'h3141592653589793238F, 80'hAAAAAAAAAAAAAAAAAAAA,
    80'h0000FFFF0000FFFF0000, 80'h2718281828459045235A,
    80'h96877869A5B4C3D2E1F0, 80'h1234567890ABCDEF1357
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance (zero key, zero IV).
  trivium_if ks ();
  trivium_core #(.KEY(80'h0), .IV(80'h0)) dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks)
  );

  // Instances for the key/IV sets.
  logic                   rk_rst  = 1'b1;
  logic                   rk_read = 1'b0;
  logic [N_SETS-1:0][7:0] rk_byte;
  logic [N_SETS-1:0]      rk_valid;

  for (genvar g = 0; g < N_SETS; g++) begin : g_set
    trivium_if u_if ();
    assign u_if.keystream_read = rk_read;
    assign rk_byte[g]          = u_if.keystream_byte;
    assign rk_valid[g]         = u_if.keystream_valid;
    trivium_core #(.KEY(RK_KEY[g]), .IV(RK_IV[g])) u_dut (
      .clk (clk),
      .rst (rk_rst),
      .ks  (u_if)
    );
  end

  logic [7:0] exp_rk [N_SETS][N_BYTES];

  typedef struct {
    logic       read;
    logic [7:0] exp_byte;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge, and inputs are
  // driven at the same point for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects valid to stay low for 144 edges after reset release and go
  // high on edge 145 with the first zero-vector byte.
  task automatic warmup(input string tag);
    int highs;
    highs = 0;
    for (int e = 1; e <= WARMUP_CYCLES; e++) begin
      tick();
      if (ks.keystream_valid !== 1'b0) highs++;
    end
    check({tag, "_valid_low_144"}, highs, 0);
    tick();
    check({tag, "_valid_edge145"}, ks.keystream_valid, 1'b1);
    check({tag, "_first_byte"}, ks.keystream_byte, 8'hFB);
  endtask

  // Bit-level model. The state uses 1-based indexing s[1..288].
  task automatic model_run(input int set, input logic [79:0] key, input logic [79:0] iv);
    logic [288:1] s;
    logic         t1, t2, t3, z;
    logic [7:0]   b;
    int           k;
    s = '0;
    b = '0;
    for (int i = 1; i <= 80; i++) s[i]      = key[i-1];
    for (int i = 1; i <= 80; i++) s[93 + i] = iv[i-1];
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    for (int r = 0; r < 1152 + 8 * N_BYTES; r++) begin
      t1 = s[66]  ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91]  & s[92])  ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      s[93:1]    = {s[92:1], t3};
      s[177:94]  = {s[176:94], t1};
      s[288:178] = {s[287:178], t2};
      if (r >= 1152) begin
        k = r - 1152;
        b[k % 8] = z;
        if (k % 8 == 7) exp_rk[set][k / 8] = b;
      end
    end
  endtask

  initial begin
    int changes;
    int waited;

    // Toggled reads starting from the first byte. Each row gives the byte
    // and valid expected after the edge. The first three bytes are consumed.
    vecs[0] = '{1'b1, 8'hFB, 1'b0};
    vecs[1] = '{1'b0, 8'hE0, 1'b1};
    vecs[2] = '{1'b1, 8'hE0, 1'b0};
    vecs[3] = '{1'b0, 8'hBF, 1'b1};
    vecs[4] = '{1'b1, 8'hBF, 1'b0};
    vecs[5] = '{1'b0, 8'h26, 1'b1};

    ks.keystream_read = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_byte",  ks.keystream_byte,  8'h00);
    check("reset_valid", ks.keystream_valid, 1'b0);

    // Warm-up from the first release.
    rst = 1'b0;
    warmup("boot");

    // Zero-vector stream at two cycles per byte.
    for (int i = 0; i < 6; i++) begin
      ks.keystream_read = vecs[i].read;
      tick();
      check($sformatf("vec%0d_byte", i),  ks.keystream_byte,  vecs[i].exp_byte);
      check($sformatf("vec%0d_valid", i), ks.keystream_valid, vecs[i].exp_valid);
    end

    // Reset after three bytes are consumed. The outputs clear without
    // waiting for a clock edge.
    rst = 1'b1;
    #1;
    check("rst_async_byte",  ks.keystream_byte,  8'h00);
    check("rst_async_valid", ks.keystream_valid, 1'b0);
    tick();
    rst = 1'b0;
    repeat (60) tick();
    check("midinit_valid_low", ks.keystream_valid, 1'b0);

    // Reset in the middle of the warm-up restarts the full 144 cycles.
    rst = 1'b1;
    #1;
    check("midinit_rst_valid", ks.keystream_valid, 1'b0);
    tick();
    rst = 1'b0;
    warmup("restart");

    // Read held for 5 cycles consumes exactly one byte.
    ks.keystream_read = 1'b1;
    tick();
    check("hold_c1_valid", ks.keystream_valid, 1'b0);
    check("hold_c1_byte",  ks.keystream_byte,  8'hFB);
    tick();
    check("hold_c2_valid", ks.keystream_valid, 1'b1);
    check("hold_c2_byte",  ks.keystream_byte,  8'hE0);
    for (int c = 3; c <= 5; c++) begin
      tick();
      check($sformatf("hold_c%0d_valid", c), ks.keystream_valid, 1'b1);
      check($sformatf("hold_c%0d_byte", c),  ks.keystream_byte,  8'hE0);
    end
    ks.keystream_read = 1'b0;

    // Idle for 1000 cycles. Nothing may move.
    changes = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (ks.keystream_byte !== 8'hE0 || ks.keystream_valid !== 1'b1) changes++;
    end
    check("idle_changes", changes, 0);

    // The stream resumes exactly where it stopped.
    ks.keystream_read = 1'b1; tick();
    ks.keystream_read = 1'b0; tick();
    check("resume_byte3", ks.keystream_byte, 8'hBF);
    ks.keystream_read = 1'b1; tick();
    ks.keystream_read = 1'b0; tick();
    check("resume_byte4",  ks.keystream_byte,  8'h26);
    check("resume_valid4", ks.keystream_valid, 1'b1);

    // Key/IV sets against the software model.
    for (int s = 0; s < N_SETS; s++) model_run(s, RK_KEY[s], RK_IV[s]);
    tick();
    rk_rst = 1'b0;
    waited = 0;
    while (!(&rk_valid) && waited < 200) begin
      tick();
      waited++;
    end
    check("rk_warmup_edges", waited, 145);
    for (int b = 0; b < N_BYTES; b++) begin
      for (int s = 0; s < N_SETS; s++)
        check($sformatf("rk_set%0d_byte%0d", s, b), rk_byte[s], exp_rk[s][b]);
      rk_read = 1'b1; tick();
      rk_read = 1'b0; tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trivium_core.md
TRIVIUM_CORE -- requirements
Module: trivium_core

Interface
REQ-001 Parameter KEY, default 80'h0, is the 80-bit secret key, with KEY[i-1] loaded into state bit s(i) for i=1..80.
REQ-002 Parameter IV, default 80'h0, is the 80-bit initialisation vector, with IV[i-1] loaded into state bit s(93+i) for i=1..80.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port keystream_read, input, 1 bit: consumer acknowledges the current byte; it is honoured only while keystream_valid=1.
REQ-006 Port keystream_byte, output, 8 bits: current keystream byte, registered.
REQ-007 Port keystream_valid, output, 1 bit: keystream_byte holds a fresh, unconsumed byte; registered.

Function
REQ-008 The block SHALL hold a 288-bit state s(1..288) and a warm-up counter of at least 8 bits.
REQ-009 Load state: s(1..80)=KEY, s(81..93)=0, s(94..173)=IV, s(174..177)=0, s(178..285)=0, s(286..288)=1.
REQ-010 One round SHALL compute t1=s66^s93, t2=s162^s177, t3=s243^s288 and output bit z=t1^t2^t3.
REQ-011 The round SHALL then update t1^=(s91&s92)^s171, t2^=(s175&s176)^s264, t3^=(s286&s287)^s69.
REQ-012 The round SHALL shift s(1..93)<=(t3,s1..s92), s(94..177)<=(t1,s94..s176), s(178..288)<=(t2,s178..s287).
REQ-013 Every state update SHALL apply exactly 8 chained rounds in one clock cycle.
REQ-014 States: INIT, READY, REFILL.
REQ-015 INIT SHALL run 144 cycles (1152 rounds) with output bits discarded; keystream_valid=0 throughout.
REQ-016 On the INIT-exit edge, the 8 rounds' outputs SHALL be latched into keystream_byte, keystream_valid SHALL go to 1, and the state SHALL move to READY.
REQ-017 Byte packing: output bit z(8n+j) SHALL go to keystream_byte[j], so the first generated bit is the LSB.
REQ-018 READY: state and byte SHALL hold while keystream_read=0.
REQ-019 READY with keystream_read=1: next edge clears keystream_valid and enters REFILL.
REQ-020 REFILL: the next edge applies 8 rounds, latches the new byte, sets keystream_valid=1 and returns to READY.
REQ-021 Sustained throughput SHALL be one byte per 2 cycles; a read lasting several cycles consumes exactly one byte.
REQ-022 keystream_read SHALL be ignored in INIT and REFILL, with no state advance and no error.
REQ-023 The state SHALL never advance in READY without a read, so no keystream byte is ever skipped.

Reset
REQ-024 While rst=1: the state is loaded per REQ-009, the counter =0, state=INIT, keystream_byte=8'h00, keystream_valid=0.
REQ-025 rst asserted at any time, including mid-INIT or mid-REFILL, SHALL abort immediately and restart the full 144-cycle warm-up after release.
REQ-026 The first INIT cycle SHALL be the first rising edge with rst=0.

Structure
REQ-027 A package trivium_pkg SHALL hold STATE_LEN=288, WARMUP_ROUNDS=1152, ROUNDS_PER_CYCLE=8, WARMUP_CYCLES=144, the tap index constants and the state enum.
REQ-028 One combinational sub-module trivium_round SHALL implement REQ-010 to REQ-012 (288-bit state in; 288-bit state and z out), instantiated 8 times in a chain.
REQ-029 No other sub-modules are permitted; the block contains no memories.

Verification
REQ-030 Warm-up: KEY=0, IV=0, release rst -> keystream_valid=0 for 144 edges, then 1 on edge 145.
REQ-031 Zero vector: KEY=0, IV=0, four reads -> bytes 8'hFB, 8'hE0, 8'hBF, 8'h26, matching the eSTREAM zero-key/zero-IV stream.
REQ-032 Handshake: hold keystream_read=1 for 5 cycles in READY -> one byte consumed, valid low 1 cycle, next byte held stable afterwards.
REQ-033 Idle hold: no read for 1000 cycles -> keystream_byte and keystream_valid unchanged.
REQ-034 Reset mid-stream: rst pulse after 3 bytes consumed -> outputs 0 immediately; after a new 144-cycle warm-up the first byte is again 8'hFB.
REQ-035 Random KEY/IV (10 sets) against a bit-accurate software model, 64 bytes each -> all bytes match.
